// File: rtl/lc3_ext_pkg.sv
// rtl/lc3_ext_pkg.sv - shared constants and field extender for lc3_ext_queue
//
// Purpose : mode encodings, LC-3 immediate field widths and the ext_field()
//           helper that extracts and extends one field from an instruction.
// Contents: MODE_* (3-bit field select), W_* (field widths), EXT_W (widest
//           supported result), ext_field(ir, mode, out_w) -> {err, neg, data}.
package lc3_ext_pkg;

  localparam logic [2:0] MODE_IMM5    = 3'd0;
  localparam logic [2:0] MODE_OFF6    = 3'd1;
  localparam logic [2:0] MODE_PCOFF9  = 3'd2;
  localparam logic [2:0] MODE_PCOFF11 = 3'd3;
  localparam logic [2:0] MODE_TRAP8   = 3'd4;
  localparam logic [2:0] MODE_PASS    = 3'd5;

  localparam int W_IMM5    = 5;
  localparam int W_OFF6    = 6;
  localparam int W_PCOFF9  = 9;
  localparam int W_PCOFF11 = 11;
  localparam int W_TRAP8   = 8;

  // Widest result the helper can build; the top truncates to OUT_W.
  localparam int EXT_W = 64;

  // ir must already be zero-extended from IN_W to EXT_W, so PASS is a copy.
  // The extension is done at full EXT_W width; bits above out_w are dropped
  // by the caller, so neg is taken from bit out_w-1 of the wide value.
  function automatic logic [EXT_W+1:0] ext_field(input logic [EXT_W-1:0] ir,
                                                 input logic [2:0]       mode,
                                                 input int               out_w);
    logic [EXT_W-1:0] d;
    logic             err;
    logic [5:0]       msb;
    d   = '0;
    err = 1'b0;
    msb = 6'(out_w - 1);
    case (mode)
      MODE_IMM5:    d = {{(EXT_W-W_IMM5){ir[W_IMM5-1]}},       ir[W_IMM5-1:0]};
      MODE_OFF6:    d = {{(EXT_W-W_OFF6){ir[W_OFF6-1]}},       ir[W_OFF6-1:0]};
      MODE_PCOFF9:  d = {{(EXT_W-W_PCOFF9){ir[W_PCOFF9-1]}},   ir[W_PCOFF9-1:0]};
      MODE_PCOFF11: d = {{(EXT_W-W_PCOFF11){ir[W_PCOFF11-1]}}, ir[W_PCOFF11-1:0]};
      MODE_TRAP8:   d = {{(EXT_W-W_TRAP8){1'b0}},              ir[W_TRAP8-1:0]};
      MODE_PASS:    d = ir;
      default:      err = 1'b1;
    endcase
    return {err, d[msb], d};
  endfunction

endpackage

// File: rtl/lc3_ext_queue_fifo.sv
// rtl/lc3_ext_queue_fifo.sv - generic valid/ready FIFO used by lc3_ext_queue
//
// Purpose : DEPTH-entry storage with wrap-around pointers and an occupancy
//           counter; DEPTH need not be a power of two.
// Ports   : clk, rst (async, active-high)
//           in_valid / in_ready / in_data[W]   - write side
//           out_valid / out_ready / out_data[W] - read side (head entry)
//           level[$clog2(DEPTH+1)]              - current occupancy
module lc3_ext_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_data,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  import lc3_ext_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Status comes only from registered level, so in_ready never depends on
  // out_ready: a full FIFO refuses a push even in a cycle where it pops.
  assign in_ready  = (level < LVL_W'(DEPTH));
  assign out_valid = (level != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Storage is not reset; gating with out_valid makes the head read as zero
  // while empty, including immediately on reset.
  assign out_data = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/lc3_ext_queue.sv
// rtl/lc3_ext_queue.sv - LC-3 immediate extractor/extender with output FIFO
//
// Purpose : extracts imm5/offset6/PCoffset9/PCoffset11/trapvect8 (or passes
//           the whole word) from ir, extends it to OUT_W bits and queues the
//           result with neg/err flags for the address adders and ALU.
// Ports   : clk, rst (async, active-high)
//           in_valid / in_ready, ir[IN_W], mode[3]      - decode side
//           out_valid / out_ready, out_data[OUT_W],
//           out_neg, out_err                            - consumer side
//           level[$clog2(DEPTH+1)]                      - FIFO occupancy
module lc3_ext_queue #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            ir,
  input  logic [2:0]                 mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_neg,
  output logic                       out_err,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  import lc3_ext_pkg::*;

  localparam int FW = OUT_W + 2;

  logic [EXT_W-1:0] ir_wide;
  logic [EXT_W+1:0] ext;
  logic [FW-1:0]    wr_entry;
  logic [FW-1:0]    rd_entry;

  assign ir_wide = EXT_W'(ir);
  assign ext     = ext_field(ir_wide, mode, OUT_W);

  // Entry layout: {err, neg, data}.
  assign wr_entry = {ext[EXT_W+1], ext[EXT_W], ext[OUT_W-1:0]};

  lc3_ext_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (wr_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (rd_entry),
    .level     (level)
  );

  assign out_data = rd_entry[OUT_W-1:0];
  assign out_neg  = rd_entry[OUT_W];
  assign out_err  = rd_entry[OUT_W+1];

endmodule

// File: tb/tb_lc3_ext_queue.sv
// tb/tb_lc3_ext_queue.sv - self-checking bench for lc3_ext_queue
module tb_lc3_ext_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] ir = '0;
  logic [2:0]  mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_neg;
  logic        out_err;
  logic [1:0]  level;

  int compared   = 0;
  int mismatched = 0;

  lc3_ext_queue #(.IN_W(16), .OUT_W(16), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ir        (ir),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_neg   (out_neg),
    .out_err   (out_err),
    .level     (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  mode;
    logic [15:0] ir;
    logic [15:0] data;
    logic        neg;
    logic        err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: mask the field, reinterpret as two's complement when signed,
  // wrap into 16 bits.  Returns {err, neg, data}.
  function automatic logic [17:0] model(input logic [15:0] w, input logic [2:0] m);
    int width;
    bit sgn;
    int f;
    int v;
    logic [15:0] d;
    case (m)
      3'd0: begin width = 5;  sgn = 1; end
      3'd1: begin width = 6;  sgn = 1; end
      3'd2: begin width = 9;  sgn = 1; end
      3'd3: begin width = 11; sgn = 1; end
      3'd4: begin width = 8;  sgn = 0; end
      3'd5: begin width = 16; sgn = 0; end
      default: return {1'b1, 1'b0, 16'h0000};
    endcase
    f = int'(w) & ((1 << width) - 1);
    v = (sgn && f >= (1 << (width - 1))) ? f - (1 << width) : f;
    d = v[15:0];
    return {1'b0, d[15], d};
  endfunction

  task automatic check_head(input string tag, input logic [15:0] d, input logic n, input logic e);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".out_data"},  32'(out_data),  32'(d));
    chk({tag, ".out_neg"},   32'(out_neg),   32'(n));
    chk({tag, ".out_err"},   32'(out_err),   32'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [17:0] exp;
    logic [17:0] q[$];
    bit          do_push;
    bit          do_pop;

    vecs[0] = '{3'd0, 16'h003F, 16'hFFFF, 1'b1, 1'b0};
    vecs[1] = '{3'd1, 16'h0020, 16'hFFE0, 1'b1, 1'b0};
    vecs[2] = '{3'd2, 16'h01FF, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{3'd3, 16'h03FF, 16'h03FF, 1'b0, 1'b0};
    vecs[4] = '{3'd4, 16'hF0FF, 16'h00FF, 1'b0, 1'b0};
    vecs[5] = '{3'd5, 16'h8001, 16'h8001, 1'b1, 1'b0};
    vecs[6] = '{3'd7, 16'hFFFF, 16'h0000, 1'b0, 1'b1};
    vecs[7] = '{3'd0, 16'hFFEF, 16'h000F, 1'b0, 1'b0};
    vecs[8] = '{3'd6, 16'h1234, 16'h0000, 1'b0, 1'b1};
    vecs[9] = '{3'd3, 16'h0400, 16'hFC00, 1'b1, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data",  32'(out_data),  32'd0);
    chk("rst.in_ready",  32'(in_ready),  32'd1);
    chk("rst.level",     32'(level),     32'd0);
    rst = 1'b0;

    // Back-to-back table vectors, one result per cycle, level stays 1
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      in_valid = 1'b1; mode = vecs[i].mode; ir = vecs[i].ir;
      @(posedge clk); @(negedge clk);
      check_head($sformatf("vec%0d", i), vecs[i].data, vecs[i].neg, vecs[i].err);
      chk($sformatf("vec%0d.level", i), 32'(level), 32'd1);
    end
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("drain.level", 32'(level), 32'd0);
    chk("drain.out_valid", 32'(out_valid), 32'd0);

    // Fill / backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; mode = 3'd0; ir = 16'h0001;
    @(posedge clk); @(negedge clk);
    chk("fill1.level", 32'(level), 32'd1);
    chk("fill1.in_ready", 32'(in_ready), 32'd1);
    ir = 16'h0002;
    @(posedge clk); @(negedge clk);
    chk("fill2.level", 32'(level), 32'd2);
    chk("fill2.in_ready", 32'(in_ready), 32'd0);
    ir = 16'h0003;
    @(posedge clk); @(negedge clk);
    chk("held.level", 32'(level), 32'd2);
    check_head("held", 16'h0001, 1'b0, 1'b0);
    out_ready = 1'b1;
    chk("popfull.in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("pop1.level", 32'(level), 32'd1);
    chk("pop1.in_ready", 32'(in_ready), 32'd1);
    check_head("pop1", 16'h0002, 1'b0, 1'b0);
    @(posedge clk); @(negedge clk);
    chk("pop2.level", 32'(level), 32'd1);
    check_head("pop2", 16'h0003, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("pop3.level", 32'(level), 32'd0);

    // Simultaneous push/pop at level 1 for 10 cycles
    out_ready = 1'b0;
    in_valid = 1'b1; mode = 3'd5; ir = 16'h1000;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      ir = 16'h1000 + 16'(k);
      @(posedge clk); @(negedge clk);
      chk($sformatf("pp%0d.level", k), 32'(level), 32'd1);
      chk($sformatf("pp%0d.data", k), 32'(out_data), 32'h1000 + 32'(k));
    end
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("pp.drain", 32'(level), 32'd0);

    // Randomized traffic against a queue model
    for (int c = 0; c < 400; c++) begin
      chk("rnd.level",     32'(level),     32'(q.size()));
      chk("rnd.in_ready",  32'(in_ready),  32'(q.size() < 2));
      chk("rnd.out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("rnd.out_data", 32'(out_data), 32'(q[0][15:0]));
        chk("rnd.out_neg",  32'(out_neg),  32'(q[0][16]));
        chk("rnd.out_err",  32'(out_err),  32'(q[0][17]));
      end
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      mode      = 3'($urandom_range(7));
      ir        = 16'($urandom);
      do_push = in_valid && (q.size() < 2);
      do_pop  = out_ready && (q.size() != 0);
      exp = model(ir, mode);
      @(posedge clk);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(exp);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rnd.drain", 32'(level), 32'd0);

    // Asynchronous reset with the FIFO full
    out_ready = 1'b0;
    in_valid = 1'b1; mode = 3'd0; ir = 16'h001F;
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("prerst.level", 32'(level), 32'd2);
    #1 rst = 1'b1;
    #1;
    chk("arst.level",     32'(level),     32'd0);
    chk("arst.in_ready",  32'(in_ready),  32'd1);
    chk("arst.out_valid", 32'(out_valid), 32'd0);
    chk("arst.out_data",  32'(out_data),  32'd0);
    chk("arst.out_neg",   32'(out_neg),   32'd0);
    chk("arst.out_err",   32'(out_err),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; mode = 3'd0; ir = 16'h000F;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("postrst.level", 32'(level), 32'd1);
    check_head("postrst", 16'h000F, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
